// File: rtl/nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_ctrl
//
// Performs a WIDTH-bit add by running one shared 4-bit adder slice over the
// operand nibbles, LSB first, one nibble per clock. A carry register links
// each slice's carry-out to the next slice's carry-in. When the last nibble
// is done, the block reports the result, the carry and the signed overflow,
// and raises a one-cycle done pulse.
//
// Optional feature macro: NIBBLE_ADD_SUB_EN
//   defined   : op_sub=1 computes a - b (B is inverted and the carry starts at 1).
//               c_out is then NOT borrow.
//   undefined : op_sub is ignored and the operation is always a + b.
//
// Parameters
//   WIDTH   operand width. Must be a multiple of 4 and at least 8.
//
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   request a new operation (sampled only in IDLE or DONE)
//   op_sub  subtract select, sampled with start
//   a, b    operands, latched on an accepted start
//   busy    operation in progress
//   done    one-cycle pulse when sum/c_out/ovf are valid
//   sum     registered result; held until the next accepted start
//   c_out   carry out of the MSB nibble
//   ovf     two's-complement signed overflow
// ---------------------------------------------------------------------------

module adder_4bits (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);
    assign {c_out, s} = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};
endmodule

module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             accept;
    logic             last;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic             carry_init;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] b_sel;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       nib_s;
    logic             nib_c;

`ifdef NIBBLE_ADD_SUB_EN
    logic sub_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_r <= 1'b0;
        end else if (accept) begin
            sub_r <= op_sub;
        end
    end

    // Subtract is a + ~b + 1. The +1 enters through the initial carry.
    assign b_sel      = sub_r ? ~b_r : b_r;
    assign carry_init = op_sub;
`else
    logic unused_op_sub;
    assign unused_op_sub = op_sub;
    assign b_sel         = b_r;
    assign carry_init    = 1'b0;
`endif

    // Select the slice inputs for the current nibble.
    assign nib_a = a_r[{idx, 2'b00} +: 4];
    assign nib_b = b_sel[{idx, 2'b00} +: 4];
    assign last  = (idx == IDX_W'(NIB - 1));

    adder_4bits u_slice (
        .a     (nib_a),
        .b     (nib_b),
        .c_in  (carry),
        .s     (nib_s),
        .c_out (nib_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // busy and done are decoded from state only.
    // There is no combinational path from the inputs to these outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand latches are plain data and need no reset.
    // They are only read in RUN, which always follows an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r <= a;
            b_r <= b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            idx   <= '0;
            carry <= carry_init;
            sum   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == S_RUN) begin
            sum[{idx, 2'b00} +: 4] <= nib_s;
            carry                  <= nib_c;
            // On the last nibble, idx may wrap. The FSM leaves RUN on this
            // same edge, so the wrapped value is never used.
            idx                    <= idx + 1'b1;
            if (last) begin
                c_out <= nib_c;
                // Carry-in to the MSB = a ^ b ^ s of the MSB.
                // Overflow = carry-in to the MSB XOR carry-out of the MSB.
                ovf   <= a_r[WIDTH-1] ^ b_sel[WIDTH-1] ^ nib_s[3] ^ nib_c;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_adder_ctrl
//
// Self-checking bench for nibble_serial_adder_ctrl with WIDTH=32.
// Expected results are pushed to a scoreboard queue when an operation is
// accepted. They are popped and compared when done pulses.
// Define NIBBLE_ADD_SUB_EN to match the DUT build.
// ---------------------------------------------------------------------------

module tb_nibble_serial_adder_ctrl;
    localparam int WIDTH = 32;
    localparam int NIB   = WIDTH / 4;
`ifdef NIBBLE_ADD_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             c;
        logic             v;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_sub (op_sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .c_out  (c_out),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    // Reference model: full-width arithmetic.
    // Signed overflow is detected from the operand and result signs.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic s);
        logic [WIDTH:0]   r;
        logic [WIDTH-1:0] yy;
        logic             sub_eff;
        exp_t             e;
        sub_eff = s & SUB_EN;
        yy      = sub_eff ? ~y : y;
        r       = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, sub_eff};
        e.sum   = r[WIDTH-1:0];
        e.c     = r[WIDTH];
        e.v     = (x[WIDTH-1] == yy[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
        return e;
    endfunction

    // Called just after a falling edge.
    // Drives one request through the accept edge and records the expectation.
    task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic s, input bit hold, input exp_t e);
        a      = x;
        b      = y;
        op_sub = s;
        start  = 1'b1;
        @(posedge clk);
        sb.push_back(e);
        #1;
        if (!hold) start = 1'b0;
    endtask

    // Counts edges after the accept edge until done is seen at a falling edge.
    task automatic wait_done(output int edges, output int bcnt, output bit timeout);
        edges   = 0;
        bcnt    = 0;
        timeout = 1'b1;
        for (int i = 0; i < 4 * NIB; i++) begin
            @(negedge clk);
            if (done) begin
                timeout = 1'b0;
                break;
            end
            if (busy) bcnt++;
            edges++;
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        op_sub = 1'b0;
        a      = '0;
        b      = '0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({busy, done, c_out, ovf} !== 4'b0000 || sum !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b sum=%h c_out=%b ovf=%b, want all 0",
                     busy, done, sum, c_out, ovf);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_add();
        logic [WIDTH-1:0] xs[8];
        logic [WIDTH-1:0] ys[8];
        exp_t             es[8];
        int               edges, bcnt;
        bit               to;
        exp_t             e;
        logic [WIDTH-1:0] held;
        xs[0] = 32'h0000000F; ys[0] = 32'h00000001; es[0] = '{32'h00000010, 1'b0, 1'b0};
        xs[1] = 32'hFFFFFFFF; ys[1] = 32'h00000001; es[1] = '{32'h00000000, 1'b1, 1'b0};
        xs[2] = 32'h7FFFFFFF; ys[2] = 32'h00000001; es[2] = '{32'h80000000, 1'b0, 1'b1};
        xs[3] = 32'h80000000; ys[3] = 32'h80000000; es[3] = '{32'h00000000, 1'b1, 1'b1};
        for (int i = 4; i < 8; i++) begin
            xs[i] = $urandom;
            ys[i] = $urandom;
            es[i] = model(xs[i], ys[i], 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            issue(xs[i], ys[i], 1'b0, 1'b0, es[i]);
            wait_done(edges, bcnt, to);
            n_tests++;
            if (to) begin
                n_fail++;
                $display("FAIL add_done_timeout[%0d]: no done within %0d cycles", i, 4 * NIB);
                void'(sb.pop_front());
                continue;
            end
            e = sb.pop_front();
            n_tests++;
            if (sum !== e.sum || c_out !== e.c || ovf !== e.v) begin
                n_fail++;
                $display("FAIL add_result[%0d]: sum=%h c=%b v=%b, want sum=%h c=%b v=%b",
                         i, sum, c_out, ovf, e.sum, e.c, e.v);
            end
            n_tests++;
            if (edges != NIB || bcnt != NIB) begin
                n_fail++;
                $display("FAIL add_latency[%0d]: done after %0d edges, busy %0d cycles, want %0d/%0d",
                         i, edges, bcnt, NIB, NIB);
            end
            held = sum;
            @(negedge clk);
            n_tests++;
            if (done !== 1'b0 || busy !== 1'b0 || sum !== held) begin
                n_fail++;
                $display("FAIL add_hold[%0d]: done=%b busy=%b sum=%h, want 0 0 %h",
                         i, done, busy, sum, held);
            end
        end
    endtask

    task automatic test_back_to_back();
        int   edges, bcnt;
        bit   to;
        exp_t e;
        issue(32'd1, 32'd2, 1'b0, 1'b1, '{32'h00000003, 1'b0, 1'b0});
        a = 32'd5;
        b = 32'd5;
        wait_done(edges, bcnt, to);
        n_tests++;
        if (to || sum !== 32'h00000003) begin
            n_fail++;
            $display("FAIL b2b_first: timeout=%b sum=%h, want 0 00000003", to, sum);
        end
        void'(sb.pop_front());
        // start is still high in DONE, so the next edge accepts 5+5.
        sb.push_back('{32'h0000000A, 1'b0, 1'b0});
        wait_done(edges, bcnt, to);
        start = 1'b0;
        n_tests++;
        if (to) begin
            n_fail++;
            $display("FAIL b2b_second_timeout: no second done");
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            n_tests++;
            if (sum !== e.sum || edges + 1 != NIB + 1) begin
                n_fail++;
                $display("FAIL b2b_second: sum=%h gap=%0d, want sum=%h gap=%0d",
                         sum, edges + 1, e.sum, NIB + 1);
            end
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int   edges, bcnt;
        bit   to;
        bit   saw_done;
        exp_t e;
        issue(32'h12345678, 32'h11111111, 1'b0, 1'b0, '{32'h23456789, 1'b0, 1'b0});
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, c_out, ovf} !== 4'b0000 || sum !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset: busy=%b done=%b sum=%h c=%b v=%b, want all 0",
                     busy, done, sum, c_out, ovf);
        end
        void'(sb.pop_back());
        @(negedge clk);
        rst_n    = 1'b1;
        saw_done = 1'b0;
        repeat (2 * NIB) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        n_tests++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL midrun_no_done: saw busy/done=1 after abort, want 0");
        end
        issue(32'h12345678, 32'h11111111, 1'b0, 1'b0, '{32'h23456789, 1'b0, 1'b0});
        wait_done(edges, bcnt, to);
        e = sb.pop_front();
        n_tests++;
        if (to || sum !== e.sum || c_out !== e.c || ovf !== e.v) begin
            n_fail++;
            $display("FAIL after_reset_add: timeout=%b sum=%h c=%b v=%b, want sum=%h c=%b v=%b",
                     to, sum, c_out, ovf, e.sum, e.c, e.v);
        end
        @(negedge clk);
    endtask

    task automatic test_sub();
        logic [WIDTH-1:0] xs[4];
        logic [WIDTH-1:0] ys[4];
        exp_t             es[4];
        int               edges, bcnt;
        bit               to;
        exp_t             e;
`ifdef NIBBLE_ADD_SUB_EN
        xs[0] = 32'd7;        ys[0] = 32'd5; es[0] = '{32'h00000002, 1'b1, 1'b0};
        xs[1] = 32'd5;        ys[1] = 32'd7; es[1] = '{32'hFFFFFFFE, 1'b0, 1'b0};
        xs[2] = 32'h80000000; ys[2] = 32'd1; es[2] = '{32'h7FFFFFFF, 1'b1, 1'b1};
`else
        xs[0] = 32'd7;        ys[0] = 32'd5; es[0] = '{32'h0000000C, 1'b0, 1'b0};
        xs[1] = 32'd5;        ys[1] = 32'd7; es[1] = '{32'h0000000C, 1'b0, 1'b0};
        xs[2] = 32'h80000000; ys[2] = 32'd1; es[2] = '{32'h80000001, 1'b0, 1'b0};
`endif
        xs[3] = $urandom;
        ys[3] = $urandom;
        es[3] = model(xs[3], ys[3], 1'b1);
        for (int i = 0; i < 4; i++) begin
            issue(xs[i], ys[i], 1'b1, 1'b0, es[i]);
            wait_done(edges, bcnt, to);
            e = sb.pop_front();
            n_tests++;
            if (to || sum !== e.sum || c_out !== e.c || ovf !== e.v) begin
                n_fail++;
                $display("FAIL sub_result[%0d]: timeout=%b sum=%h c=%b v=%b, want sum=%h c=%b v=%b",
                         i, to, sum, c_out, ovf, e.sum, e.c, e.v);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_reset_mid_run();
        test_sub();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

A multi-cycle controller that performs a WIDTH-bit add (optionally subtract) by sequencing one shared `adder_4bits` slice over successive nibbles, LSB first. It latches the operands on a start request and steps a nibble index. A carry register chains each slice's carry-out into the next slice's carry-in. When finished it reports the result, carry and signed overflow with a one-cycle done pulse. It sits beside the ALU as a low-area arithmetic unit for wide operands.

## Interface
- `WIDTH`, default 32: operand width in bits.
  - Must be a multiple of 4 and at least 8.
  - NIB = WIDTH/4 nibble steps.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request a new operation; sampled only when the block is in IDLE or DONE.
- `op_sub`, input, 1: 1 selects a − b. Sampled with `start`. Ignored unless NIBBLE_ADD_SUB_EN is defined.
- `a`, input, WIDTH: operand A, latched on an accepted `start`.
- `b`, input, WIDTH: operand B, latched on an accepted `start`.
- `busy`, output, 1: operation in progress (state RUN).
- `done`, output, 1: one-cycle pulse when the result is valid (state DONE).
- `sum`, output, WIDTH: result register; holds its value until the next accepted start or reset.
- `c_out`, output, 1: final carry out of the MSB nibble. For subtract, 1 means no borrow.
- `ovf`, output, 1: two's-complement signed overflow of the full-width operation.

## Operation
- **States:** IDLE, RUN, DONE. Encoding is free.
- **IDLE:**
  - `busy`=0, `done`=0.
  - If `start`=1, latch `a`→A_r and `b`→B_r, and set idx←0.
  - Set carry←`op_sub` (with the macro) or 0 (without), and clear `sum`←0.
  - Go to RUN.
- **RUN (one slice per cycle):**
  - Slice inputs: A = A_r[4·idx+3:4·idx]; B = Bsel[4·idx+3:4·idx]; C_in = carry.
  - Bsel = ~B_r when subtracting, otherwise B_r.
  - Each edge: `sum`[4·idx+3:4·idx]←S; carry←C_out; idx←idx+1.
  - On the edge where idx = NIB−1:
    - `c_out`←C_out.
    - `ovf`←A_r[WIDTH−1] ^ Bsel[WIDTH−1] ^ S[3] ^ C_out.
    - Go to DONE.
  - `start` is ignored throughout RUN; there is no queuing.
- **DONE (exactly one cycle):**
  - `done`=1, `busy`=0.
  - If `start`=1, accept a new operation exactly as from IDLE and go to RUN. Otherwise go to IDLE.
- **Outputs:** `sum`, `c_out` and `ovf` are registered and stable from DONE until the next accepted start. `c_out` and `ovf` clear on an accepted start.
- **Width rules:** idx is a ceil(log2(NIB))-bit counter. No wrap beyond NIB−1, because the state changes first. Carry is 1 bit.
- **Reset:**
  - Asynchronous assert forces IDLE; idx, carry, `sum`, `c_out`, `ovf`, `busy` and `done` all go to 0.
  - Reset mid-RUN aborts the operation; no `done` is produced for it.
  - Operation resumes on the first edge after deassertion.

## Timing
- Accept edge E0: `start` is sampled high in IDLE or DONE.
- `busy` is high from after E0 through after E(NIB−1), i.e. NIB cycles.
- `done` is high for the single cycle following edge E(NIB). For WIDTH=32, that is 8 cycles after acceptance.
- Back-to-back: `start` held high in DONE gives a new busy window starting immediately. Throughput is one operation per NIB+1 cycles.
- Combinational paths: only the slice-input mux and `adder_4bits`, between registers. There are no combinational input-to-output paths.

## Configuration
- **`NIBBLE_ADD_SUB_EN` defined:**
  - `op_sub` is honored: B is inverted into the slice and the initial carry = 1.
  - `c_out` = NOT borrow; `ovf` is the signed subtract overflow.
- **Not defined:**
  - The port remains but is ignored; the operation is always a + b and the initial carry = 0.
  - No inversion logic is synthesized.

## Test plan
- 0x0000000F + 0x00000001, WIDTH=32 → `sum`=0x00000010, `c_out`=0, `ovf`=0, `done` pulses exactly once, 8 cycles after the accept edge, with `busy` high for 8 cycles.
- 0xFFFFFFFF + 0x00000001 → `sum`=0x00000000, `c_out`=1, `ovf`=0. Also 0x7FFFFFFF + 0x00000001 → `sum`=0x80000000, `c_out`=0, `ovf`=1.
- `start` held high continuously, with operands 1+2 first and then changed to 5+5 while busy → first result `sum`=3. The changed operands during RUN are ignored. A second operation (5+5) is accepted in the DONE cycle, giving `sum`=0x0000000A after 9 more cycles.
- `rst_n` pulsed low during the 4th RUN cycle of 0x12345678 + 0x11111111 → all outputs 0 immediately and no `done`. A following 0x12345678 + 0x11111111 gives `sum`=0x23456789.
- With NIBBLE_ADD_SUB_EN:
  - 7 − 5 → `sum`=0x00000002, `c_out`=1.
  - 5 − 7 → `sum`=0xFFFFFFFE, `c_out`=0.
  - 0x80000000 − 1 → `sum`=0x7FFFFFFF, `ovf`=1.
- Without the macro: `op_sub`=1 with 7 and 5 → `sum`=0x0000000C (add performed).
